// File: rtl/fai_arbiter.sv
// Round-robin arbiter sharing one fetch-and-increment unit among clients.
// Optional WAIT-state abort enabled by defining FAI_TIMEOUT_EN.
`timescale 1ns/1ps
module fai_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] cli_req,
  output logic [NUM_CLIENTS-1:0] cli_rsp_valid,
  output logic [DATA_W-1:0]      cli_rsp_value,
  output logic                   cli_rsp_err,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   busy,
  output logic                   fai_req,
  input  logic                   fai_ack,
  input  logic [DATA_W-1:0]      fai_value,
  output logic                   fai_err
);

  if (NUM_CLIENTS < 2 || TIMEOUT_CYC < 1 || DATA_W < 1) begin : g_bad_cfg
    $error("fai_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic                   r_busy;
  logic                   r_fai_req;
  logic                   r_fai_err;
  logic [NUM_CLIENTS-1:0] r_rsp_valid;
  logic [DATA_W-1:0]      r_rsp_value;

  logic                   w_any;
  logic [IDX_W-1:0]       w_win;
  logic [IDX_W:0]         w_cand;
  logic [IDX_W:0]         w_nxt;
  logic [NUM_CLIENTS-1:0] w_onehot;

  // Scan downward so the lowest offset from rr_ptr is the final winner.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_rr_ptr;
    w_cand = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_CLIENTS))
        w_cand = w_cand - (IDX_W+1)'(NUM_CLIENTS);
      if (cli_req[w_cand[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_nxt = {1'b0, w_win} + (IDX_W+1)'(1);
    if (w_nxt >= (IDX_W+1)'(NUM_CLIENTS))
      w_nxt = '0;
  end

  assign w_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << r_gnt_idx;

`ifdef FAI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_busy      <= 1'b0;
      r_fai_req   <= 1'b0;
      r_fai_err   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_value <= '0;
`ifdef FAI_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_fai_req   <= 1'b0;
      r_rsp_valid <= '0;
      if (fai_ack && r_state != S_WAIT)
        r_fai_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_ISSUE;
            r_gnt_idx <= w_win;
            r_rr_ptr  <= w_nxt[IDX_W-1:0];
            r_fai_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef FAI_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (fai_ack) begin
            r_state     <= S_RESP;
            r_rsp_valid <= w_onehot;
            r_rsp_value <= fai_value;
`ifdef FAI_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= w_onehot;
            r_rsp_value <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
`endif
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cli_rsp_valid = r_rsp_valid;
  assign cli_rsp_value = r_rsp_value;
  assign gnt_idx       = r_gnt_idx;
  assign busy          = r_busy;
  assign fai_req       = r_fai_req;
  assign fai_err       = r_fai_err;
`ifdef FAI_TIMEOUT_EN
  assign cli_rsp_err   = r_rsp_err;
`else
  assign cli_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fai_arbiter.sv
// Directed bench for fai_arbiter with a behavioural FAI counter model.
// Timeout scenario runs only when FAI_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fai_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cli_req;
  logic [3:0]  cli_rsp_valid;
  logic [31:0] cli_rsp_value;
  logic        cli_rsp_err;
  logic [1:0]  gnt_idx;
  logic        busy;
  logic        fai_req;
  logic        fai_ack;
  logic [31:0] fai_value;
  logic        fai_err;

  logic        ack_en;
  logic        spur;
  logic        load;
  logic [31:0] load_val;
  logic [31:0] m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fai_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cli_req       (cli_req),
    .cli_rsp_valid (cli_rsp_valid),
    .cli_rsp_value (cli_rsp_value),
    .cli_rsp_err   (cli_rsp_err),
    .gnt_idx       (gnt_idx),
    .busy          (busy),
    .fai_req       (fai_req),
    .fai_ack       (fai_ack),
    .fai_value     (fai_value),
    .fai_err       (fai_err)
  );

  // FAI unit: acks one cycle after sampling fai_req, returns prior count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fai_ack   <= 1'b0;
      fai_value <= '0;
      m_cnt     <= '0;
    end else begin
      fai_ack <= (ack_en && fai_req) || spur;
      if (ack_en && fai_req) begin
        fai_value <= m_cnt;
        m_cnt     <= m_cnt + 32'd1;
      end else if (load) begin
        m_cnt <= load_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rsp(input int g, input logic [31:0] v,
                          input int lat, input bit drop);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (|cli_rsp_valid) seen = 1'b1;
    end
    chk("rsp_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("rsp_lat", 64'(n), 64'(lat));
      chk("rsp_onehot", 64'(cli_rsp_valid), 64'(4'b0001 << g));
      chk("rsp_value", 64'(cli_rsp_value), 64'(v));
      chk("rsp_err", 64'(cli_rsp_err), 64'd0);
      chk("rsp_gnt", 64'(gnt_idx), 64'(g));
      if (drop) cli_req[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cli_req = '0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    cli_req  = '0;
    ack_en   = 1'b1;
    spur     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    idle(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fai_req", 64'(fai_req), 64'd0);
    chk("rst_valid", 64'(cli_rsp_valid), 64'd0);
    chk("rst_value", 64'(cli_rsp_value), 64'd0);
    chk("rst_gnt", 64'(gnt_idx), 64'd0);
    chk("rst_fai_err", 64'(fai_err), 64'd0);
    chk("rst_err", 64'(cli_rsp_err), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // single client 2, detailed timing
    cli_req = 4'b0100;
    @(negedge clk);
    chk("t1_fai_req", 64'(fai_req), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_gnt", 64'(gnt_idx), 64'd2);
    @(negedge clk);
    chk("t1_fai_req_low", 64'(fai_req), 64'd0);
    chk("t1_wait_valid", 64'(cli_rsp_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(cli_rsp_valid), 64'(4'b0100));
    chk("t1_value", 64'(cli_rsp_value), 64'd0);
    chk("t1_busy_resp", 64'(busy), 64'd1);
    cli_req = '0;
    @(negedge clk);
    chk("t1_valid_off", 64'(cli_rsp_valid), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);
    idle(1);
    cli_req = 4'b0100;
    wait_rsp(2, 32'd1, 3, 1'b1);

    // full contention from reset
    idle(2);
    do_reset();
    cli_req = 4'b1111;
    wait_rsp(0, 32'd0, 3, 1'b0);
    wait_rsp(1, 32'd1, 4, 1'b0);
    wait_rsp(2, 32'd2, 4, 1'b0);
    wait_rsp(3, 32'd3, 4, 1'b0);
    wait_rsp(0, 32'd4, 4, 1'b0);
    cli_req = '0;
    idle(2);

    // round-robin wrap: after grant 3, 1 wins before 3
    cli_req = 4'b1000;
    wait_rsp(3, 32'd5, 3, 1'b1);
    idle(2);
    cli_req = 4'b1010;
    wait_rsp(1, 32'd6, 3, 1'b1);
    wait_rsp(3, 32'd7, 4, 1'b1);
    idle(2);

    // client 0 drops request while in WAIT
    cli_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    cli_req = '0;
    @(negedge clk);
    chk("cancel_valid", 64'(cli_rsp_valid), 64'(4'b0001));
    chk("cancel_value", 64'(cli_rsp_value), 64'd8);
    idle(2);
    cli_req = 4'b0001;
    wait_rsp(0, 32'd9, 3, 1'b1);
    chk("fai_err_clean", 64'(fai_err), 64'd0);
    idle(2);

    // ticket wrap-around with a single back-to-back requester
    load_val = 32'hFFFF_FFFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cli_req = 4'b0100;
    wait_rsp(2, 32'hFFFF_FFFF, 3, 1'b0);
    wait_rsp(2, 32'h0000_0000, 4, 1'b1);
    idle(2);

    // spurious ack in IDLE
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_fai_err", 64'(fai_err), 64'd1);
    chk("spur_busy", 64'(busy), 64'd0);
    cli_req = 4'b0010;
    wait_rsp(1, 32'd1, 3, 1'b1);
    chk("spur_sticky", 64'(fai_err), 64'd1);
    idle(2);

    // reset during WAIT
    cli_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    cli_req = '0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_gnt", 64'(gnt_idx), 64'd0);
    chk("mrst_fai_req", 64'(fai_req), 64'd0);
    chk("mrst_valid", 64'(cli_rsp_valid), 64'd0);
    chk("mrst_fai_err", 64'(fai_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    cli_req = 4'b0010;
    wait_rsp(1, 32'd0, 3, 1'b1);
    idle(2);
    chk("mrst_no_err", 64'(fai_err), 64'd0);

`ifdef FAI_TIMEOUT_EN
    ack_en = 1'b0;
    cli_req = 4'b1000;
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if (|cli_rsp_valid) seen = 1'b1;
      end
      chk("to_seen", 64'(seen), 64'd1);
      chk("to_lat", 64'(n), 64'd18);
      chk("to_valid", 64'(cli_rsp_valid), 64'(4'b1000));
      chk("to_value", 64'(cli_rsp_value), 64'd0);
      chk("to_err", 64'(cli_rsp_err), 64'd1);
    end
    cli_req = '0;
    @(negedge clk);
    chk("to_idle", 64'(busy), 64'd0);
    ack_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
